spi_sequencer: RTL and testbench

SPI_SEQUENCER -- requirements
Module: spi_sequencer

---
 rtl/spi_seq_pkg.sv | 23 ++
 rtl/spi_seq_fifo.sv | 64 ++++++
 rtl/spi_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_spi_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI burst sequencer: FSM state encoding and default widths.
// Imported by spi_seq_fifo and spi_sequencer.
package spi_seq_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_DIV_W  = 8;
    localparam int DEF_LEN_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SS_SETUP = 3'd1,
        ST_LOAD     = 3'd2,
        ST_XFER     = 3'd3,
        ST_SS_HOLD  = 3'd4
    } seq_state_e;

    // Index width for a FIFO of the given depth; never below one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous FIFO with full/empty flags; accepts push and pop in the same cycle,
// including a push into a full FIFO that is being popped in that cycle.
module spi_seq_fifo
    import spi_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/spi_sequencer.sv
// Burst sequencer driving an SPI master: slave select, SCK tick divider, TX/RX buffering.
// Define SPI_SEQ_RXFIFO_EN for a DEPTH-entry RX FIFO; otherwise RX is a single holding register.
module spi_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DIV_W  = DEF_DIV_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic              go_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              tx_wr_i,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              tx_full_o,
    input  logic              rx_rd_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_empty_o,
    output logic              rx_ovf_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              ss_n_o,
    output logic              m_ena_o,
    output logic              m_start_o,
    output logic [DATA_W-1:0] m_tx_o,
    input  logic [DATA_W-1:0] m_rx_i,
    input  logic              m_irq_i,
    output logic              m_ack_o
);

    seq_state_e        state_q;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [LEN_W-1:0]  remain_q;
    logic [DATA_W-1:0] m_tx_q;
    logic              ss_n_q, busy_q, done_q, start_q, ack_q, ovf_q;

    logic              tx_empty, tx_pop;
    logic [DATA_W-1:0] tx_head;
    logic              rx_push, rx_full, rx_overflow;
    logic              go_ok, last_byte, div_clr, ena;

    assign ena       = (div_cnt_q == div_i);
    assign go_ok     = (state_q == ST_IDLE) && go_i && (len_i != '0);
    assign last_byte = (remain_q == LEN_W'(1));
    // NOTE: FIFO strobes are combinational so the pop/push lands in the same cycle the FSM acts.
    assign tx_pop    = (state_q == ST_LOAD) && !tx_empty;
    assign rx_push   = (state_q == ST_XFER) && m_irq_i;
    // A push into a full RX path is lost unless a host pop frees room in that same cycle.
    assign rx_overflow = rx_push && rx_full && !rx_rd_i;

    // Divider restarts on a new byte and on entry to the select setup/hold phases.
    assign div_clr = start_q || go_ok || (rx_push && last_byte);

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (div_clr || (div_cnt_q >= div_i)) div_cnt_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) div_cnt_q <= '0;
        else       div_cnt_q <= div_cnt_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            m_tx_q   <= '0;
            ss_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            ack_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            if (rx_overflow) ovf_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (go_ok) begin
                        state_q  <= ST_SS_SETUP;
                        ss_n_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        remain_q <= len_i;
                        ovf_q    <= 1'b0;
                    end
                end
                ST_SS_SETUP: begin
                    if (ena) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (!tx_empty) begin
                        m_tx_q  <= tx_head;
                        start_q <= 1'b1;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (m_irq_i) begin
                        ack_q    <= 1'b1;
                        remain_q <= remain_q - LEN_W'(1);
                        state_q  <= last_byte ? ST_SS_HOLD : ST_LOAD;
                    end
                end
                ST_SS_HOLD: begin
                    if (ena) begin
                        ss_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    spi_seq_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tx_wr_i),
        .data_i  (tx_data_i),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .full_o  (tx_full_o),
        .empty_o (tx_empty)
    );

`ifdef SPI_SEQ_RXFIFO_EN
    spi_seq_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rx_push),
        .data_i  (m_rx_i),
        .pop_i   (rx_rd_i),
        .data_o  (rx_data_o),
        .full_o  (rx_full),
        .empty_o (rx_empty_o)
    );
`else
    logic              rx_valid_q;
    logic [DATA_W-1:0] rx_hold_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_valid_q <= 1'b0;
            rx_hold_q  <= '0;
        end else if (rx_push) begin
            rx_valid_q <= 1'b1;
            rx_hold_q  <= m_rx_i;
        end else if (rx_rd_i) begin
            rx_valid_q <= 1'b0;
        end
    end

    assign rx_full    = rx_valid_q;
    assign rx_empty_o = !rx_valid_q;
    assign rx_data_o  = rx_hold_q;
`endif

    assign rx_ovf_o  = ovf_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign ss_n_o    = ss_n_q;
    assign m_ena_o   = ena;
    assign m_start_o = start_q;
    assign m_tx_o    = m_tx_q;
    assign m_ack_o   = ack_q;

endmodule

// File: tb/tb_spi_sequencer.sv
// Directed bench for spi_sequencer with an echoing SPI master model.
// Expectations follow the build: SPI_SEQ_RXFIFO_EN selects RX FIFO vs holding register.
module tb_spi_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] div_i;
    logic       go_i;
    logic [7:0] len_i;
    logic       tx_wr_i;
    logic [7:0] tx_data_i;
    logic       tx_full_o;
    logic       rx_rd_i;
    logic [7:0] rx_data_o;
    logic       rx_empty_o, rx_ovf_o, busy_o, done_o, ss_n_o;
    logic       m_ena_o, m_start_o, m_ack_o, m_irq_i;
    logic [7:0] m_tx_o, m_rx_i;

    int         n_checks = 0;
    int         n_errors = 0;
    int         done_cnt = 0;
    int         bad_ss = 0;
    int         ack_timeouts = 0;
    int         irq_delay = 2;
    logic [7:0] tx_log [$];

    spi_sequencer dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .div_i     (div_i),
        .go_i      (go_i),
        .len_i     (len_i),
        .tx_wr_i   (tx_wr_i),
        .tx_data_i (tx_data_i),
        .tx_full_o (tx_full_o),
        .rx_rd_i   (rx_rd_i),
        .rx_data_o (rx_data_o),
        .rx_empty_o(rx_empty_o),
        .rx_ovf_o  (rx_ovf_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .ss_n_o    (ss_n_o),
        .m_ena_o   (m_ena_o),
        .m_start_o (m_start_o),
        .m_tx_o    (m_tx_o),
        .m_rx_i    (m_rx_i),
        .m_irq_i   (m_irq_i),
        .m_ack_o   (m_ack_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Master model: logs each started word, answers with an echo after irq_delay cycles.
    initial begin
        m_irq_i = 1'b0;
        m_rx_i  = '0;
        forever begin
            @(posedge clk_i); #1;
            if (m_start_o && !rst_i) begin
                tx_log.push_back(m_tx_o);
                for (int k = 0; k < irq_delay && !rst_i; k++) begin
                    @(posedge clk_i); #1;
                end
                if (!rst_i) begin
                    m_rx_i  = m_tx_o;
                    m_irq_i = 1'b1;
                    for (int k = 0; k < 64 && !m_ack_o && !rst_i; k++) begin
                        @(posedge clk_i); #1;
                    end
                    if (!m_ack_o && !rst_i) ack_timeouts++;
                    m_irq_i = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_i); #1;
            if (done_o) done_cnt++;
            if (busy_o && ss_n_o) bad_ss++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_tx(input logic [7:0] d);
        @(negedge clk_i);
        tx_wr_i   = 1'b1;
        tx_data_i = d;
        @(negedge clk_i);
        tx_wr_i   = 1'b0;
    endtask

    task automatic pop_rx();
        @(negedge clk_i);
        rx_rd_i = 1'b1;
        @(negedge clk_i);
        rx_rd_i = 1'b0;
    endtask

    task automatic start_burst(input logic [7:0] n);
        @(negedge clk_i);
        go_i  = 1'b1;
        len_i = n;
        @(negedge clk_i);
        go_i  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_idle_timeout"}, busy_o, 0);
    endtask

    task automatic wait_starts(input int want, input string tag);
        int n = 0;
        while (tx_log.size() < want && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_start_timeout"}, tx_log.size(), want);
    endtask

    task automatic count_ena(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            if (m_ena_o) pulses++;
        end
    endtask

    task automatic drain_rx();
        for (int i = 0; i < 8 && !rx_empty_o; i++) pop_rx();
    endtask

    initial begin
        int d0;
        int pulses;

        rst_i     = 1'b1;
        div_i     = 8'd3;
        go_i      = 1'b0;
        len_i     = '0;
        tx_wr_i   = 1'b0;
        tx_data_i = '0;
        rx_rd_i   = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        check("rst_ss_n",     ss_n_o,     1);
        check("rst_busy",     busy_o,     0);
        check("rst_done",     done_o,     0);
        check("rst_start",    m_start_o,  0);
        check("rst_ack",      m_ack_o,    0);
        check("rst_ovf",      rx_ovf_o,   0);
        check("rst_tx_full",  tx_full_o,  0);
        check("rst_rx_empty", rx_empty_o, 1);

        // Divider period: div+1 clocks per tick.
        count_ena(40, pulses);
        check("ena_div3", pulses, 10);
        div_i = 8'd0;
        count_ena(20, pulses);
        check("ena_div0", pulses, 20);
        div_i = 8'd3;

        // go with zero length is ignored.
        start_burst(8'd0);
        check("len0_busy", busy_o, 0);

        // Single-byte echo burst.
        tx_log.delete();
        d0 = done_cnt;
        push_tx(8'hA5);
        start_burst(8'd1);
        check("b1_busy", busy_o, 1);
        check("b1_ss_low", ss_n_o, 0);
        wait_idle("b1");
        @(negedge clk_i);
        check("b1_starts", tx_log.size(), 1);
        check("b1_m_tx", tx_log[0], 8'hA5);
        check("b1_done_once", done_cnt - d0, 1);
        check("b1_ss_high", ss_n_o, 1);
        check("b1_rx_empty", rx_empty_o, 0);
        check("b1_rx_data", rx_data_o, 8'hA5);
        pop_rx();
        check("b1_rx_popped", rx_empty_o, 1);

        // Four-word burst.
        tx_log.delete();
        push_tx(8'h11);
        push_tx(8'h22);
        push_tx(8'h33);
        check("b4_not_full", tx_full_o, 0);
        push_tx(8'h44);
        check("b4_tx_full", tx_full_o, 1);
        start_burst(8'd4);
        wait_idle("b4");
        check("b4_starts", tx_log.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("b4_m_tx%0d", i), tx_log[i], 8'h11 * (i + 1));
        check("b4_tx_empty_after", tx_full_o, 0);
`ifdef SPI_SEQ_RXFIFO_EN
        check("b4_ovf", rx_ovf_o, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b4_rx%0d", i), rx_data_o, 8'h11 * (i + 1));
            pop_rx();
        end
`else
        check("b4_ovf", rx_ovf_o, 1);
        check("b4_rx_last", rx_data_o, 8'h44);
        pop_rx();
`endif
        check("b4_rx_drained", rx_empty_o, 1);

        // Underrun stall in LOAD, resumed by a late push.
        tx_log.delete();
        d0 = done_cnt;
        push_tx(8'h5A);
        start_burst(8'd2);
        wait_starts(1, "stall");
        repeat (30) @(negedge clk_i);
        check("stall_starts", tx_log.size(), 1);
        check("stall_busy", busy_o, 1);
        check("stall_ss_low", ss_n_o, 0);
        check("stall_no_done", done_cnt - d0, 0);
        check("stall_rx_first", rx_data_o, 8'h5A);
        pop_rx();
        push_tx(8'hC3);
        wait_idle("stall");
        @(negedge clk_i);
        check("stall_starts_end", tx_log.size(), 2);
        check("stall_m_tx1", tx_log[1], 8'hC3);
        check("stall_done", done_cnt - d0, 1);
        check("stall_rx_second", rx_data_o, 8'hC3);
        pop_rx();

        // RX overflow and its clearing by the next accepted go.
`ifdef SPI_SEQ_RXFIFO_EN
        for (int i = 1; i <= 4; i++) push_tx(8'(i));
        start_burst(8'd4);
        wait_idle("ovf_fill");
        check("ovf_fill_clear", rx_ovf_o, 0);
        push_tx(8'h99);
        start_burst(8'd1);
        wait_idle("ovf_drop");
        check("ovf_set", rx_ovf_o, 1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf_rx%0d", i), rx_data_o, i);
            pop_rx();
        end
`else
        push_tx(8'h77);
        start_burst(8'd1);
        wait_idle("ovf_fill");
        check("ovf_fill_clear", rx_ovf_o, 0);
        push_tx(8'h99);
        start_burst(8'd1);
        wait_idle("ovf_drop");
        check("ovf_set", rx_ovf_o, 1);
        check("ovf_overwrite", rx_data_o, 8'h99);
        pop_rx();
`endif
        check("ovf_rx_empty", rx_empty_o, 1);
        push_tx(8'h12);
        start_burst(8'd1);
        check("ovf_cleared_by_go", rx_ovf_o, 0);
        wait_idle("ovf_next");
        check("ovf_next_rx", rx_data_o, 8'h12);
        pop_rx();

        // Reset while in XFER aborts at once without a done pulse.
        tx_log.delete();
        irq_delay = 40;
        push_tx(8'hE7);
        start_burst(8'd1);
        wait_starts(1, "abort");
        check("abort_busy_before", busy_o, 1);
        d0 = done_cnt;
        rst_i = 1'b1;
        #1;
        check("abort_ss_n", ss_n_o, 1);
        check("abort_busy", busy_o, 0);
        check("abort_start", m_start_o, 0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_rx_empty", rx_empty_o, 1);
        check("abort_tx_full", tx_full_o, 0);
        irq_delay = 2;

        // Push into a full TX FIFO in the same cycle as the sequencer pop.
        tx_log.delete();
        for (int i = 0; i < 4; i++) push_tx(8'hA0 + 8'(i));
        check("wrap_full", tx_full_o, 1);
        @(negedge clk_i);
        tx_wr_i   = 1'b1;
        tx_data_i = 8'hA4;
        repeat (8) @(negedge clk_i);
        start_burst(8'd5);
        wait_starts(1, "wrap");
        check("wrap_full_kept", tx_full_o, 1);
        tx_wr_i = 1'b0;
        wait_idle("wrap");
        check("wrap_starts", tx_log.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("wrap_m_tx%0d", i), tx_log[i], 8'hA0 + i);
        check("wrap_tx_empty", tx_full_o, 0);
        drain_rx();

        check("ss_low_while_busy", bad_ss, 0);
        check("ack_timeouts", ack_timeouts, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
